// File: rtl/fifo4x4_if.sv
// Handshake bundle between a producer/consumer pair and the 4-entry FIFO.
// The master side drives requests and data; the slave side returns data and status.
interface fifo4x4_if #(
    parameter int WIDTH  = 4,
    parameter int ADDR_W = 2
);
    logic              clr;
    logic              wr_en;
    logic [WIDTH-1:0]  din;
    logic              rd_en;
    logic [WIDTH-1:0]  dout;
    logic              empty;
    logic              full;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic              underflow;

    modport master (
        output clr, wr_en, din, rd_en,
        input  dout, empty, full, count, overflow, underflow
    );

    modport slave (
        input  clr, wr_en, din, rd_en,
        output dout, empty, full, count, overflow, underflow
    );
endinterface

// File: rtl/fifo4x4.sv
// Small synchronous FIFO with registered read data and sticky misuse flags.
// A full FIFO still takes a write when a read is accepted in the same cycle.
module fifo4x4 #(
    parameter int WIDTH  = 4,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    fifo4x4_if.slave   bus
);
    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W+1)'(DEPTH);

    logic [WIDTH-1:0]  mem [DEPTH];

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [WIDTH-1:0]  dout_q, dout_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;

    logic empty, full, rd_ok, wr_ok;

    assign empty = (count_q == '0);
    assign full  = (count_q == FULL_COUNT);
    assign rd_ok = bus.rd_en & ~empty;
    // No fall-through: a read on an empty FIFO is refused even if a write lands this cycle.
    assign wr_ok = bus.wr_en & (~full | rd_ok);

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        dout_d      = dout_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (bus.clr) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            dout_d      = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr_d = wr_ptr_q + ADDR_W'(1);
            end
            if (rd_ok) begin
                rd_ptr_d = rd_ptr_q + ADDR_W'(1);
                dout_d   = mem[rd_ptr_q];
            end
            case ({wr_ok, rd_ok})
                2'b10:   count_d = count_q + (ADDR_W+1)'(1);
                2'b01:   count_d = count_q - (ADDR_W+1)'(1);
                default: count_d = count_q;
            endcase
            if (bus.wr_en && !wr_ok) begin
                overflow_d = 1'b1;
            end
            if (bus.rd_en && empty) begin
                underflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            dout_q      <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            dout_q      <= dout_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is not reset; only the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (reset_n && wr_ok && !bus.clr) begin
            mem[wr_ptr_q] <= bus.din;
        end
    end

    assign bus.dout      = dout_q;
    assign bus.empty     = empty;
    assign bus.full      = full;
    assign bus.count     = count_q;
    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;
endmodule

// File: tb/tb_fifo4x4.sv
// Directed bench for fifo4x4: hand-computed expectations for reset, fill/drain,
// overflow, underflow, simultaneous access, pointer wrap, clear and async reset.
module tb_fifo4x4;
    logic clk = 1'b1;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;

    fifo4x4_if #(.WIDTH(4), .ADDR_W(2)) bus ();

    fifo4x4 #(.WIDTH(4), .DEPTH(4), .ADDR_W(2)) u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    // Apply one cycle of inputs, let the edge happen, sample 1 ns later, then idle the inputs.
    task automatic cycle(input logic wr, input logic [3:0] d, input logic rd, input logic cl);
        bus.wr_en = wr;
        bus.din   = d;
        bus.rd_en = rd;
        bus.clr   = cl;
        @(posedge clk);
        #1;
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        bus.clr   = 1'b0;
    endtask

    task automatic write_word(input logic [3:0] d);
        cycle(1'b1, d, 1'b0, 1'b0);
    endtask

    task automatic read_expect(input string tag, input logic [3:0] exp);
        cycle(1'b0, 4'h0, 1'b1, 1'b0);
        check(tag, {4'h0, bus.dout}, {4'h0, exp});
    endtask

    task automatic fill_std();
        write_word(4'b1100);
        write_word(4'b0110);
        write_word(4'b0101);
        write_word(4'b0000);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n   = 1'b0;
        bus.clr   = 1'b0;
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        bus.din   = 4'h0;
        #15 reset_n = 1'b1;
        #1;
        check("rst_dout",  {4'h0, bus.dout}, 8'h00);
        check("rst_empty", {7'h0, bus.empty}, 8'h01);
        check("rst_full",  {7'h0, bus.full}, 8'h00);
        check("rst_count", {5'h0, bus.count}, 8'h00);
        check("rst_ovf",   {7'h0, bus.overflow}, 8'h00);
        check("rst_udf",   {7'h0, bus.underflow}, 8'h00);

        // Fill and drain
        fill_std();
        check("fill_full",  {7'h0, bus.full}, 8'h01);
        check("fill_count", {5'h0, bus.count}, 8'h04);
        read_expect("drain1", 4'b1100);
        read_expect("drain2", 4'b0110);
        read_expect("drain3", 4'b0101);
        read_expect("drain4", 4'b0000);
        check("drain_empty", {7'h0, bus.empty}, 8'h01);
        check("drain_count", {5'h0, bus.count}, 8'h00);

        // Overflow: write while full is dropped
        fill_std();
        write_word(4'b1111);
        check("ovf_count", {5'h0, bus.count}, 8'h04);
        check("ovf_flag",  {7'h0, bus.overflow}, 8'h01);
        read_expect("ovf_drain1", 4'b1100);
        read_expect("ovf_drain2", 4'b0110);
        read_expect("ovf_drain3", 4'b0101);
        read_expect("ovf_drain4", 4'b0000);
        check("ovf_empty",  {7'h0, bus.empty}, 8'h01);
        check("ovf_sticky", {7'h0, bus.overflow}, 8'h01);
        check("udf_clean",  {7'h0, bus.underflow}, 8'h00);

        // Simultaneous read+write on empty: write only, underflow set
        cycle(1'b1, 4'b1010, 1'b1, 1'b0);
        check("sim_empty_udf",   {7'h0, bus.underflow}, 8'h01);
        check("sim_empty_count", {5'h0, bus.count}, 8'h01);
        check("sim_empty_dout",  {4'h0, bus.dout}, 8'h00);
        read_expect("sim_empty_read", 4'b1010);
        check("sim_empty_cnt0", {5'h0, bus.count}, 8'h00);

        // Simultaneous read+write on full, pointers wrap
        fill_std();
        cycle(1'b1, 4'b1001, 1'b1, 1'b0);
        check("sim_full_dout",  {4'h0, bus.dout}, 8'h0c);
        check("sim_full_count", {5'h0, bus.count}, 8'h04);
        read_expect("wrap1", 4'b0110);
        read_expect("wrap2", 4'b0101);
        read_expect("wrap3", 4'b0000);
        read_expect("wrap4", 4'b1001);
        check("wrap_empty", {7'h0, bus.empty}, 8'h01);

        // clr mid-operation with a concurrent write
        write_word(4'b0001);
        write_word(4'b0010);
        check("clr_pre_count", {5'h0, bus.count}, 8'h02);
        cycle(1'b1, 4'b0111, 1'b0, 1'b1);
        check("clr_count", {5'h0, bus.count}, 8'h00);
        check("clr_empty", {7'h0, bus.empty}, 8'h01);
        check("clr_ovf",   {7'h0, bus.overflow}, 8'h00);
        check("clr_udf",   {7'h0, bus.underflow}, 8'h00);
        check("clr_dout",  {4'h0, bus.dout}, 8'h00);
        write_word(4'b0011);
        check("post_clr_count", {5'h0, bus.count}, 8'h01);
        read_expect("post_clr_read", 4'b0011);
        cycle(1'b0, 4'h0, 1'b1, 1'b0);
        check("post_clr_udf",  {7'h0, bus.underflow}, 8'h01);
        check("post_clr_hold", {4'h0, bus.dout}, 8'h03);

        // Asynchronous reset mid-operation
        write_word(4'b0100);
        write_word(4'b1000);
        #2 reset_n = 1'b0;
        #1;
        check("arst_count", {5'h0, bus.count}, 8'h00);
        check("arst_dout",  {4'h0, bus.dout}, 8'h00);
        check("arst_udf",   {7'h0, bus.underflow}, 8'h00);
        #2 reset_n = 1'b1;
        write_word(4'b1110);
        read_expect("arst_read", 4'b1110);
        check("arst_empty", {7'h0, bus.empty}, 8'h01);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
